// File: rtl/byte_striping.sv
// Round-robin byte striper: spreads a single-lane byte stream across LANES
// registered output lanes, with group-completion, resync and partial-group reporting.
module byte_striping #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int PTR_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  input  logic                   align_in,
  output logic [LANES*WIDTH-1:0] lane_data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   group_done,
  output logic                   partial_err,
  output logic [CNT_W-1:0]       group_count,
  output logic [PTR_W-1:0]       lane_ptr
);

  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  logic [WIDTH-1:0] lane_reg [LANES];
  logic [LANES-1:0] valid_reg, valid_next;
  logic             done_reg, done_next;
  logic             perr_reg, perr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             wr_en;
  logic [PTR_W-1:0] wr_lane;

  // Align wins over a normal accept: the coincident byte is redirected to
  // lane 0, so group_done and partial_err can never fire together.
  always_comb begin
    wr_en      = 1'b0;
    wr_lane    = ptr_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    perr_next  = 1'b0;
    count_next = count_reg;
    if (align_in) begin
      perr_next = (ptr_reg != '0);
      if (valid_in) begin
        wr_en    = 1'b1;
        wr_lane  = '0;
        ptr_next = PTR_W'(1);
      end else begin
        ptr_next = '0;
      end
    end else if (valid_in) begin
      wr_en   = 1'b1;
      wr_lane = ptr_reg;
      if (ptr_reg == LAST_LANE) begin
        ptr_next   = '0;
        done_next  = 1'b1;
        count_next = count_reg + CNT_W'(1);
      end else begin
        ptr_next = ptr_reg + PTR_W'(1);
      end
    end
    valid_next = wr_en ? (LANES'(1) << wr_lane) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      valid_reg <= '0;
      done_reg  <= 1'b0;
      perr_reg  <= 1'b0;
      count_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
      perr_reg  <= perr_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Lane contents persist until overwritten; only reset clears them.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!reset_L) begin
          lane_reg[gi] <= '0;
        end else if (wr_en && (wr_lane == PTR_W'(gi))) begin
          lane_reg[gi] <= data_in;
        end
      end
      assign lane_data_out[gi*WIDTH +: WIDTH] = lane_reg[gi];
    end
  endgenerate

  assign valid_out   = valid_reg;
  assign group_done  = done_reg;
  assign partial_err = perr_reg;
  assign group_count = count_reg;
  assign lane_ptr    = ptr_reg;

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping (LANES=4, WIDTH=8, CNT_W=8): directed
// vectors push hand-computed expectations; a monitor pops and compares each cycle.
module tb_byte_striping;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        align_in;
  logic [31:0] lane_data_out;
  logic [3:0]  valid_out;
  logic        group_done;
  logic        partial_err;
  logic [7:0]  group_count;
  logic [1:0]  lane_ptr;

  byte_striping #(.LANES(4), .WIDTH(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .data_in(data_in),
    .valid_in(valid_in),
    .align_in(align_in),
    .lane_data_out(lane_data_out),
    .valid_out(valid_out),
    .group_done(group_done),
    .partial_err(partial_err),
    .group_count(group_count),
    .lane_ptr(lane_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [3:0]  v;
    logic [31:0] lanes;
    logic        chk_lanes;
    logic [1:0]  ptr;
    logic        done;
    logic        perr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step  = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  // Monitor: one expected snapshot per clock, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_out",   e.idx, 32'(valid_out),   32'(e.v));
        check("lane_ptr",    e.idx, 32'(lane_ptr),    32'(e.ptr));
        check("group_done",  e.idx, 32'(group_done),  32'(e.done));
        check("partial_err", e.idx, 32'(partial_err), 32'(e.perr));
        check("group_count", e.idx, 32'(group_count), 32'(e.cnt));
        if (e.chk_lanes) check("lane_data", e.idx, lane_data_out, e.lanes);
        $display("[TB] step %0d: valid=%b ptr=%0d done=%b perr=%b cnt=%0d lanes=%h",
                 e.idx, valid_out, lane_ptr, group_done, partial_err, group_count, lane_data_out);
      end
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic a, input logic [7:0] d,
                     input logic [3:0] ev, input logic [31:0] el, input logic cl,
                     input logic [1:0] ep, input logic ed, input logic epe, input logic [7:0] ec);
    exp_t e;
    reset_L  = rst;
    valid_in = v;
    align_in = a;
    data_in  = d;
    @(posedge clk);
    e.idx = step; e.v = ev; e.lanes = el; e.chk_lanes = cl;
    e.ptr = ep; e.done = ed; e.perr = epe; e.cnt = ec;
    exp_q.push_back(e);
    step++;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int drain;
    //  rst v a data   valid   lanes(3..0)  chk ptr done perr cnt
    cyc(0, 1, 0, 8'hFF, 4'b0000, 32'h00000000, 1, 0, 0, 0, 8'd0);
    cyc(0, 1, 0, 8'hFF, 4'b0000, 32'h00000000, 1, 0, 0, 0, 8'd0);
    // continuous stream
    cyc(1, 1, 0, 8'h11, 4'b0001, 32'h00000011, 1, 1, 0, 0, 8'd0);
    cyc(1, 1, 0, 8'h22, 4'b0010, 32'h00002211, 1, 2, 0, 0, 8'd0);
    cyc(1, 1, 0, 8'h33, 4'b0100, 32'h00332211, 1, 3, 0, 0, 8'd0);
    cyc(1, 1, 0, 8'h44, 4'b1000, 32'h44332211, 1, 0, 1, 0, 8'd1);
    cyc(1, 1, 0, 8'h55, 4'b0001, 32'h44332255, 1, 1, 0, 0, 8'd1);
    // align without byte at ptr=1: partial error, pointer back to 0
    cyc(1, 0, 1, 8'h00, 4'b0000, 32'h44332255, 1, 0, 0, 1, 8'd1);
    // gapped stream
    cyc(1, 1, 0, 8'hA0, 4'b0001, 32'h443322A0, 1, 1, 0, 0, 8'd1);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'h443322A0, 1, 1, 0, 0, 8'd1);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'h443322A0, 1, 1, 0, 0, 8'd1);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'h443322A0, 1, 1, 0, 0, 8'd1);
    cyc(1, 1, 0, 8'hA1, 4'b0010, 32'h4433A1A0, 1, 2, 0, 0, 8'd1);
    cyc(1, 1, 0, 8'hA2, 4'b0100, 32'h44A2A1A0, 1, 3, 0, 0, 8'd1);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'h44A2A1A0, 1, 3, 0, 0, 8'd1);
    cyc(1, 1, 0, 8'hA3, 4'b1000, 32'hA3A2A1A0, 1, 0, 1, 0, 8'd2);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'hA3A2A1A0, 1, 0, 0, 0, 8'd2);
    // align mid-group with coincident byte
    cyc(1, 1, 0, 8'h01, 4'b0001, 32'hA3A2A101, 1, 1, 0, 0, 8'd2);
    cyc(1, 1, 0, 8'h02, 4'b0010, 32'hA3A20201, 1, 2, 0, 0, 8'd2);
    cyc(1, 1, 1, 8'h03, 4'b0001, 32'hA3A20203, 1, 1, 0, 1, 8'd2);
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'hA3A20203, 1, 1, 0, 0, 8'd2);
    cyc(1, 1, 0, 8'h04, 4'b0010, 32'hA3A20403, 1, 2, 0, 0, 8'd2);
    cyc(1, 1, 0, 8'h05, 4'b0100, 32'hA3050403, 1, 3, 0, 0, 8'd2);
    cyc(1, 1, 0, 8'h06, 4'b1000, 32'h06050403, 1, 0, 1, 0, 8'd3);
    // align at ptr=0: no error, alone and with a byte
    cyc(1, 0, 1, 8'h00, 4'b0000, 32'h06050403, 1, 0, 0, 0, 8'd3);
    cyc(1, 1, 1, 8'h07, 4'b0001, 32'h06050407, 1, 1, 0, 0, 8'd3);
    // align at ptr=3 with a byte: redirected to lane 0, no group_done
    cyc(1, 1, 0, 8'h08, 4'b0010, 32'h06050807, 1, 2, 0, 0, 8'd3);
    cyc(1, 1, 0, 8'h09, 4'b0100, 32'h06090807, 1, 3, 0, 0, 8'd3);
    cyc(1, 1, 1, 8'h0A, 4'b0001, 32'h0609080A, 1, 1, 0, 1, 8'd3);
    // reset mid-group
    cyc(1, 1, 0, 8'h0B, 4'b0010, 32'h06090B0A, 1, 2, 0, 0, 8'd3);
    cyc(0, 1, 0, 8'hFF, 4'b0000, 32'h00000000, 1, 0, 0, 0, 8'd0);
    cyc(1, 1, 0, 8'h0C, 4'b0001, 32'h0000000C, 1, 1, 0, 0, 8'd0);
    cyc(1, 0, 1, 8'h00, 4'b0000, 32'h0000000C, 1, 0, 0, 1, 8'd0);
    // counter wrap: 257 full groups, every byte of group g carries g[7:0]
    for (int g = 1; g <= 257; g++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(1, 1, 0, 8'(g), 4'(1 << k), 32'h01010101, (g == 257 && k == 3),
            2'((k + 1) % 4), (k == 3), 1'b0, (k == 3) ? 8'(g) : 8'(g - 1));
      end
    end
    cyc(1, 0, 0, 8'h00, 4'b0000, 32'h01010101, 1, 0, 0, 0, 8'd1);
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
